// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; a single-digit operation still needs a 1-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry into the top bit.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic c;

  always_comb begin
    c     = ci;
    c_msb = ci;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: one digit_adder slice reused WIDTH/DIGIT times, LSB digit first,
// with a start/ready/done handshake and registered sum, carry-out and signed overflow.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_e           state_q;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co, dig_cmsb;
  logic [WIDTH-1:0] psum_d;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters from the MSB side so the LSB digit ends up at bit 0 after N steps.
  assign psum_d = (psum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_co;
          psum_q  <= psum_d;
          if (cnt_q == LAST) begin
            sum_q   <= psum_d;
            cout_q  <= dig_co;
            ovf_q   <= dig_co ^ dig_cmsb;
            done_q  <= 1'b1;
            state_q <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8/1 and a 16/4 instance checked against an arithmetic reference.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int total = 0;
  int bad = 0;
  logic [7:0] last_exp8 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  // Reference: {overflow, cout, sum} from plain integer addition of w-bit operands.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input int w);
    longint full, mask;
    logic [15:0] s;
    logic co, ov;
    mask = (64'sd1 <<< w) - 1;
    full = longint'(x) + longint'(y) + longint'(c);
    s    = 16'(full & mask);
    co   = full[w];
    ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  // Launches one operation and waits (bounded) for done; returns edges from acceptance to done.
  task automatic do_op(input bit wide, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, output int lat);
    @(negedge clk);
    if (wide) begin a16 = ta; b16 = tb_; cin16 = tc; start16 = 1'b1; end
    else begin a8 = ta[7:0]; b8 = tb_[7:0]; cin8 = tc; start8 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if ((wide ? done16 : done8) === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin bad++;
      $display("FAIL reset_ctrl8: ready=%b busy=%b done=%b need 1 0 0", ready8, busy8, done8); end
    total++; if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin bad++;
      $display("FAIL reset_res8: sum=%h cout=%b ovf=%b need 00 0 0", sum8, cout8, ovf8); end
    total++; if (ready16 !== 1'b1 || busy16 !== 1'b0 || sum16 !== 16'h0) begin bad++;
      $display("FAIL reset16: ready=%b busy=%b sum=%h need 1 0 0000", ready16, busy16, sum16); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready8 !== 1'b1 || done8 !== 1'b0) begin bad++;
      $display("FAIL idle_after_reset: ready=%b done=%b need 1 0", ready8, done8); end
    last_exp8 = 8'h00;
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h5A, 8'hFF, 8'h80, 8'h00};
    logic [7:0] vb [4] = '{8'h3C, 8'h01, 8'h80, 8'h00};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es [4] = '{8'h96, 8'h00, 8'h00, 8'h01};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int k = 0; k < 4; k++) begin
      do_op(1'b0, {8'h0, va[k]}, {8'h0, vb[k]}, vc[k], lat);
      total++; if (lat !== 8) begin bad++;
        $display("FAIL dir_latency[%0d]: got %0d need 8", k, lat); end
      total++; if (sum8 !== es[k] || cout8 !== ec[k] || ovf8 !== eo[k]) begin bad++;
        $display("FAIL dir_result[%0d]: sum=%h cout=%b ovf=%b need %h %b %b",
                 k, sum8, cout8, ovf8, es[k], ec[k], eo[k]); end
      total++; if (ready8 !== 1'b1) begin bad++;
        $display("FAIL dir_ready_done[%0d]: ready=%b need 1", k, ready8); end
      last_exp8 = es[k];
      @(negedge clk);
      total++; if (done8 !== 1'b0) begin bad++;
        $display("FAIL dir_pulse[%0d]: done=%b one cycle later, need 0", k, done8); end
    end
  endtask

  task automatic test_random8();
    logic [7:0] ra, rb; logic rc; logic [17:0] e; int lat; int nbad = 0;
    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      e = ref_add({8'h0, ra}, {8'h0, rb}, rc, 8);
      do_op(1'b0, {8'h0, ra}, {8'h0, rb}, rc, lat);
      total++;
      if (lat !== 8 || sum8 !== e[7:0] || cout8 !== e[16] || ovf8 !== e[17]) begin bad++; nbad++;
        if (nbad < 5) $display("FAIL rand8 %h+%h+%b: lat=%0d sum=%h cout=%b ovf=%b need 8 %h %b %b",
                               ra, rb, rc, lat, sum8, cout8, ovf8, e[7:0], e[16], e[17]); end
      last_exp8 = e[7:0];
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] ra, rb; logic [17:0] e; int ndone = 0, first = -1, idle_busy = 0, moved = 0;
    ra = 8'($urandom); rb = 8'($urandom);
    e = ref_add({8'h0, ra}, {8'h0, rb}, 1'b0, 8);
    @(negedge clk);
    a8 = ra; b8 = rb; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 8 && busy8 !== 1'b1) idle_busy++;
      if (i < 8 && sum8 !== last_exp8) moved++;
      if (done8 === 1'b1) begin ndone++; if (first < 0) first = i; end
      if (i == 3) begin a8 = 8'h11; b8 = 8'h22; start8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
    end
    total++; if (idle_busy !== 0) begin bad++;
      $display("FAIL busy_held: busy low in %0d RUN cycles, need 0", idle_busy); end
    total++; if (ndone !== 1 || first !== 8) begin bad++;
      $display("FAIL busy_done_count: pulses=%0d first=%0d need 1 at 8", ndone, first); end
    total++; if (sum8 !== e[7:0] || cout8 !== e[16] || ovf8 !== e[17]) begin bad++;
      $display("FAIL busy_result: sum=%h cout=%b ovf=%b need %h %b %b",
               sum8, cout8, ovf8, e[7:0], e[16], e[17]); end
    total++; if (moved !== 0) begin bad++;
      $display("FAIL busy_sum_stable: sum changed in %0d RUN cycles, need 0", moved); end
    last_exp8 = e[7:0];
  endtask

  task automatic test_back_to_back();
    logic [7:0] xa [2], xb [2]; logic [7:0] es [2];
    logic [17:0] e; logic [7:0] hold; int d [2] = '{-1, -1}; int nd = 0, moved = 0;
    for (int k = 0; k < 2; k++) begin
      xa[k] = 8'($urandom); xb[k] = 8'($urandom);
      e = ref_add({8'h0, xa[k]}, {8'h0, xb[k]}, 1'b0, 8);
      es[k] = e[7:0];
    end
    hold = last_exp8;
    @(negedge clk);
    a8 = xa[0]; b8 = xb[0]; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = xa[1]; b8 = xb[1];
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        if (nd < 2) begin
          d[nd] = i;
          total++; if (sum8 !== es[nd]) begin bad++;
            $display("FAIL b2b_sum[%0d]: got %h need %h", nd, sum8, es[nd]); end
          hold = es[nd];
        end
        nd++;
        if (nd == 2) start8 = 1'b0;
      end else if (sum8 !== hold) moved++;
      if (i == 9) begin a8 = 8'($urandom); b8 = 8'($urandom); end
    end
    total++; if (nd !== 2 || d[0] !== 8 || d[1] - d[0] !== 9) begin bad++;
      $display("FAIL b2b_spacing: pulses=%0d at %0d,%0d need 2 at 8,17", nd, d[0], d[1]); end
    total++; if (moved !== 0) begin bad++;
      $display("FAIL b2b_sum_only_on_done: %0d off-done changes, need 0", moved); end
    last_exp8 = es[1];
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0; int lat;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin bad++;
      $display("FAIL midrst_ctrl: ready=%b busy=%b done=%b need 1 0 0", ready8, busy8, done8); end
    total++; if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin bad++;
      $display("FAIL midrst_res: sum=%h cout=%b ovf=%b need 00 0 0", sum8, cout8, ovf8); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++;
      $display("FAIL midrst_no_done: %0d pulses need 0", ndone); end
    do_op(1'b0, 16'h0010, 16'h0020, 1'b0, lat);
    total++; if (lat !== 8 || sum8 !== 8'h30 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin bad++;
      $display("FAIL midrst_after: lat=%0d sum=%h cout=%b ovf=%b need 8 30 0 0",
               lat, sum8, cout8, ovf8); end
    last_exp8 = 8'h30;
  endtask

  task automatic test_wide();
    logic [15:0] ra, rb; logic rc; logic [17:0] e; int lat; int nbad = 0;
    do_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, lat);
    total++; if (lat !== 4) begin bad++;
      $display("FAIL wide_latency: got %0d need 4", lat); end
    total++; if (sum16 !== 16'h8000 || cout16 !== 1'b0 || ovf16 !== 1'b1) begin bad++;
      $display("FAIL wide_result: sum=%h cout=%b ovf=%b need 8000 0 1", sum16, cout16, ovf16); end
    for (int k = 0; k < 15; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (k == 0) begin ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; end
      e = ref_add(ra, rb, rc, 16);
      do_op(1'b1, ra, rb, rc, lat);
      total++;
      if (lat !== 4 || sum16 !== e[15:0] || cout16 !== e[16] || ovf16 !== e[17]) begin bad++; nbad++;
        if (nbad < 5) $display("FAIL rand16 %h+%h+%b: lat=%0d sum=%h cout=%b ovf=%b need 4 %h %b %b",
                               ra, rb, rc, lat, sum16, cout16, ovf16, e[15:0], e[16], e[17]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
